seq_detect_ctrl: RTL and testbench

//  Programmable serial-pattern detection controller. Software configures a pattern,
//  its length, a target match count and an idle timeout, then pulses start.
//  The block scans a qualified serial bit stream, counts overlapping matches and

---
 rtl/seq_det_pkg.sv | 11 +
 rtl/seq_match_core.sv | 38 +++
 rtl/seq_detect_ctrl.sv | 94 +++++++++
 tb/tb_seq_detect_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared widths, state encoding and width helper for the pattern detector
package seq_det_pkg;
   function automatic int len_w_of(input int pat_w);
      return $clog2(pat_w) + 1;
   endfunction
   localparam int PAT_W = 8;
   localparam int LEN_W = len_w_of(PAT_W);
   localparam int CNT_W = 8;
   localparam int TO_W  = 16;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: bit history, fill counter and masked pattern compare
module seq_match_core
   import seq_det_pkg::*;
#(
   parameter int PAT_W = seq_det_pkg::PAT_W,
   parameter int LEN_W = len_w_of(PAT_W)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             bit_in,
   input  logic [PAT_W-1:0] pattern,
   input  logic [LEN_W-1:0] len,
   output logic             hit
);
   logic [PAT_W-1:0] hist, hist_nx, mask;
   logic [LEN_W-1:0] fill, fill_nx;
   // hit looks at the post-shift history so a match is flagged on the completing bit
   always_comb begin
      hist_nx = {hist[PAT_W-2:0], bit_in};
      fill_nx = (fill == LEN_W'(PAT_W)) ? fill : fill + LEN_W'(1);
      mask    = ~({PAT_W{1'b1}} << len);
      hit     = shift_en && (fill_nx >= len) && ((hist_nx & mask) == (pattern & mask));
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist <= '0;
         fill <= '0;
      end else if (clr) begin
         hist <= '0;
         fill <= '0;
      end else if (shift_en) begin
         hist <= hist_nx;
         fill <= fill_nx;
      end
   end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial pattern detector with match target and idle timeout
module seq_detect_ctrl
   import seq_det_pkg::*;
#(
   parameter int PAT_W = seq_det_pkg::PAT_W,
   parameter int LEN_W = len_w_of(PAT_W),
   parameter int CNT_W = seq_det_pkg::CNT_W,
   parameter int TO_W  = seq_det_pkg::TO_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic [CNT_W-1:0] cfg_target,
   input  logic [TO_W-1:0]  cfg_timeout,
   input  logic             start,
   input  logic             abort,
   input  logic             bit_valid,
   input  logic             bit_in,
   output logic             busy,
   output logic             match_pulse,
   output logic [CNT_W-1:0] match_count,
   output logic             done,
   output logic             timed_out
);
   state_t           state;
   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] len_q;
   logic [CNT_W-1:0] tgt_q, cnt_nx;
   logic [TO_W-1:0]  to_q, timer;
   logic             len_ok, launch, hit;
   assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W));
   assign launch = start && len_ok && !abort && (state != S_RUN);
   assign cnt_nx = (match_count == '1) ? match_count : match_count + CNT_W'(1);
   assign busy   = (state == S_RUN);
   seq_match_core #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_core (
      .clk      (clk),
      .reset    (reset),
      .clr      (launch),
      .shift_en (busy && bit_valid),
      .bit_in   (bit_in),
      .pattern  (pat_q),
      .len      (len_q),
      .hit      (hit)
   );
   // abort beats everything; in RUN a match beats the timeout
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         pat_q       <= '0;
         len_q       <= '0;
         tgt_q       <= '0;
         to_q        <= '0;
         timer       <= '0;
         match_pulse <= 1'b0;
         match_count <= '0;
         done        <= 1'b0;
         timed_out   <= 1'b0;
      end else begin
         match_pulse <= 1'b0;
         if (abort) begin
            state     <= S_IDLE;
            done      <= 1'b0;
            timed_out <= 1'b0;
         end else if (state != S_RUN) begin
            if (launch) begin
               state       <= S_RUN;
               pat_q       <= cfg_pattern;
               len_q       <= cfg_len;
               tgt_q       <= cfg_target;
               to_q        <= cfg_timeout;
               timer       <= '0;
               match_count <= '0;
               done        <= 1'b0;
               timed_out   <= 1'b0;
            end
         end else if (hit) begin
            match_pulse <= 1'b1;
            match_count <= cnt_nx;
            timer       <= '0;
            if (tgt_q != '0 && cnt_nx == tgt_q) begin
               state <= S_DONE;
               done  <= 1'b1;
            end
         end else if (to_q != '0 && timer == to_q - TO_W'(1)) begin
            state     <= S_DONE;
            done      <= 1'b1;
            timed_out <= 1'b1;
         end else begin
            timer <= timer + TO_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed and random stimulus checked against a queue-based reference model
module tb_seq_detect_ctrl;
   import seq_det_pkg::*;
   logic             clk = 1'b0;
   logic             reset;
   logic [PAT_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic [CNT_W-1:0] cfg_target;
   logic [TO_W-1:0]  cfg_timeout;
   logic             start, abort, bit_valid, bit_in;
   logic             busy, match_pulse, done, timed_out;
   logic [CNT_W-1:0] match_count;
   int n_vec = 0;
   int n_err = 0;
   // reference model: 0 idle, 1 run, 2 done; history kept as a queue of received bits
   int m_state, m_pat, m_len, m_tgt, m_to, m_cnt, m_timer;
   bit m_pulse, m_done, m_tof;
   bit hq[$];

   seq_detect_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_target  (cfg_target),
      .cfg_timeout (cfg_timeout),
      .start       (start),
      .abort       (abort),
      .bit_valid   (bit_valid),
      .bit_in      (bit_in),
      .busy        (busy),
      .match_pulse (match_pulse),
      .match_count (match_count),
      .done        (done),
      .timed_out   (timed_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0; m_pat = 0; m_len = 0; m_tgt = 0; m_to = 0;
      m_cnt = 0; m_timer = 0; m_pulse = 0; m_done = 0; m_tof = 0;
      hq.delete();
   endtask

   task automatic model_step();
      bit hit;
      int v;
      m_pulse = 0;
      if (abort) begin
         m_state = 0; m_done = 0; m_tof = 0;
      end else if (m_state != 1) begin
         if (start && cfg_len >= 1 && cfg_len <= PAT_W) begin
            m_pat = int'(cfg_pattern); m_len = int'(cfg_len);
            m_tgt = int'(cfg_target);  m_to = int'(cfg_timeout);
            hq.delete();
            m_cnt = 0; m_timer = 0; m_done = 0; m_tof = 0; m_state = 1;
         end
      end else begin
         hit = 0;
         if (bit_valid) begin
            hq.push_back(bit_in);
            if (hq.size() > PAT_W) void'(hq.pop_front());
            if (hq.size() >= m_len) begin
               v = 0;
               for (int i = hq.size() - m_len; i < hq.size(); i++) v = v * 2 + int'(hq[i]);
               hit = (v == m_pat % (1 << m_len));
            end
         end
         if (hit) begin
            m_pulse = 1;
            m_cnt = (m_cnt < (1 << CNT_W) - 1) ? m_cnt + 1 : m_cnt;
            m_timer = 0;
            if (m_tgt != 0 && m_cnt == m_tgt) begin m_state = 2; m_done = 1; end
         end else if (m_to != 0 && m_timer == m_to - 1) begin
            m_state = 2; m_done = 1; m_tof = 1;
         end else begin
            m_timer++;
         end
      end
   endtask

   task automatic check_outputs();
      chk("busy", 32'(busy), 32'(m_state == 1));
      chk("match_pulse", 32'(match_pulse), 32'(m_pulse));
      chk("match_count", 32'(match_count), 32'(m_cnt));
      chk("done", 32'(done), 32'(m_done));
      chk("timed_out", 32'(timed_out), 32'(m_tof));
   endtask

   task automatic cyc(input logic s, input logic a, input logic v, input logic b);
      start = s; abort = a; bit_valid = v; bit_in = b;
      @(posedge clk);
      if (reset) model_reset(); else model_step();
      @(negedge clk);
      check_outputs();
      start = 0; abort = 0; bit_valid = 0; bit_in = 0;
   endtask

   task automatic set_cfg(input int p, input int l, input int t, input int to);
      cfg_pattern = PAT_W'(p); cfg_len = LEN_W'(l);
      cfg_target = CNT_W'(t); cfg_timeout = TO_W'(to);
   endtask

   initial begin
      int first_done;
      int seq1 [7] = '{1, 0, 1, 1, 0, 1, 1};
      logic [PAT_W-1:0] p8;
      reset = 1; start = 0; abort = 0; bit_valid = 0; bit_in = 0;
      set_cfg(0, 0, 0, 0);
      model_reset();
      @(negedge clk);
      check_outputs();
      cyc(0, 0, 1, 1);
      reset = 0;

      // 1: overlapping pattern 1011, target 2
      set_cfg(8'h0B, 4, 2, 0);
      cyc(1, 0, 0, 0);
      foreach (seq1[i]) cyc(0, 0, 1, 1'(seq1[i]));
      chk("t1_count", 32'(match_count), 2);
      chk("t1_done", 32'(done), 1);
      cyc(0, 0, 1, 1);

      // 2: 111 over eight ones, unlimited target, then abort keeps count
      set_cfg(3'b111, 3, 0, 0);
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1);
      chk("t2_count", 32'(match_count), 6);
      chk("t2_busy", 32'(busy), 1);
      cyc(0, 1, 0, 0);
      chk("t2_abort_count", 32'(match_count), 6);

      // 3: timeout of 10 with no bits
      set_cfg(1, 1, 0, 10);
      cyc(1, 0, 0, 0);
      first_done = 0;
      for (int k = 1; k <= 14; k++) begin
         cyc(0, 0, 0, 0);
         if (done && first_done == 0) first_done = k;
      end
      chk("t3_latency", 32'(first_done), 10);
      chk("t3_timed_out", 32'(timed_out), 1);

      // 4: illegal lengths ignored, start during RUN ignored
      cyc(0, 1, 0, 0);
      set_cfg(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      set_cfg(1, PAT_W + 1, 0, 0);
      cyc(1, 0, 0, 0);
      chk("t4_busy", 32'(busy), 0);
      set_cfg(2'b10, 2, 0, 0);
      cyc(1, 0, 0, 0);
      set_cfg(1, 1, 1, 3);
      cyc(1, 0, 1, 1);
      cyc(0, 0, 1, 0);
      cyc(0, 0, 1, 1);

      // 5: match on the expiry cycle wins, then abort+start together
      cyc(0, 1, 0, 0);
      set_cfg(1, 1, 0, 4);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 1);
      chk("t5_no_timeout", 32'(timed_out), 0);
      chk("t5_count", 32'(match_count), 1);
      for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
      cyc(1, 1, 0, 0);
      chk("t5_abort_start", 32'(busy), 0);

      // 6: reset mid-run after two matches, then len=8 needs eight fresh bits
      set_cfg(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 1);
      cyc(0, 0, 1, 1);
      reset = 1;
      #1;
      model_reset();
      check_outputs();
      cyc(0, 0, 1, 1);
      reset = 0;
      p8 = PAT_W'($urandom);
      set_cfg(int'(p8), PAT_W, 0, 0);
      cyc(1, 0, 0, 0);
      for (int i = PAT_W - 1; i >= 0; i--) cyc(0, 0, 1, p8[i]);
      chk("t6_first_hit", 32'(match_count), 1);

      // saturation of the match counter with unlimited target
      cyc(0, 1, 0, 0);
      set_cfg(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 260; i++) cyc(0, 0, 1, 1);
      chk("sat_count", 32'(match_count), 255);
      cyc(0, 1, 0, 0);

      // random traffic
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 15) == 0)
            set_cfg(int'($urandom), int'($urandom_range(0, PAT_W + 1)),
                    int'($urandom_range(0, 5)), int'($urandom_range(0, 20)));
         cyc(1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 59) == 0),
             1'($urandom_range(0, 2) != 0), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
